// File: rtl/spi_master_engine.sv
// -----------------------------------------------------------------------------
// spi_master_engine
//   SPI master frame engine: 1..4 byte frames, CPOL/CPHA modes, MSB/LSB first,
//   integrated SCK divider and NSS_NUM slave selects (automatic or manual).
//
// Ports
//   clk_i, rst_n_i        system clock, asynchronous active-low reset
//   en_i                  engine enable; low aborts a frame in progress
//   cpol_i, cpha_i        SCK idle level / sample on trailing edge
//   lsb_i                 1: LSB first
//   ass_i                 1: automatic NSS, 0: NSS follows nss_i
//   dtb_i                 frame bytes minus one
//   nss_i                 slave-select mask (1 = select)
//   div_i                 SCK half-period = div_i+1 clk_i cycles
//   tx_valid_i/tx_ready_o TX handshake, tx_data_i right-justified
//   rx_valid_o, rx_data_o one-cycle RX strobe with right-justified word
//   busy_o, done_o        frame in progress / one-cycle completion pulse
//   spi_sck_o, spi_nss_o, spi_mosi_o, spi_miso_i   serial interface
// -----------------------------------------------------------------------------
module spi_master_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NSS_NUM    = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic                  ass_i,
    input  logic [1:0]            dtb_i,
    input  logic [NSS_NUM-1:0]    nss_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  spi_sck_o,
    output logic [NSS_NUM-1:0]    spi_nss_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic [1:0]            dtb_q, dtb_d;
    logic [NSS_NUM-1:0]    nssm_q, nssm_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rxsh_q, rxsh_d;
    logic [6:0]            edge_q, edge_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic [NSS_NUM-1:0]    nss_q, nss_d;
    logic [DATA_WIDTH-1:0] rxd_q, rxd_d;
    logic                  rxv_q, rxv_d;
    logic                  done_q, done_d;

    logic       tick, accept;
    logic [6:0] nbits, nbits_in, s_idx, d_idx, s_pos, d_pos;
    logic       d_bit, first_bit;

    assign tick     = (cnt_q == '0);
    assign accept   = tx_valid_i & tx_ready_o;
    assign nbits    = 7'({dtb_q, 3'b000}) + 7'd8;
    assign nbits_in = 7'({dtb_i, 3'b000}) + 7'd8;

    // edge_q counts SCK edges already produced; bit k is sampled on edge 2k+1
    // (cpha=0) or 2k+2 (cpha=1), so the sampled bit is always edge_q/2. The
    // driven bit is one ahead for cpha=0 because bit 0 was driven in SETUP.
    assign s_idx = {1'b0, edge_q[6:1]};
    assign d_idx = cpha_q ? s_idx : s_idx + 7'd1;
    assign s_pos = lsb_q ? s_idx : nbits - 7'd1 - s_idx;
    assign d_pos = lsb_q ? d_idx : nbits - 7'd1 - d_idx;
    assign d_bit = (d_idx < nbits) && (|(tx_q & (ONE << d_pos)));
    assign first_bit = |(tx_data_i & (ONE << (lsb_i ? 7'd0 : nbits_in - 7'd1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        dtb_d   = dtb_q;
        nssm_d  = nssm_q;
        tx_d    = tx_q;
        rxsh_d  = rxsh_q;
        edge_d  = edge_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        rxd_d   = rxd_q;
        rxv_d   = 1'b0;
        done_d  = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = tick ? div_q : cnt_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                sck_d  = cpol_i;
                mosi_d = 1'b0;
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = div_i;
                    div_d   = div_i;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    lsb_d   = lsb_i;
                    dtb_d   = dtb_i;
                    nssm_d  = nss_i;
                    tx_d    = tx_data_i;
                    rxsh_d  = '0;
                    edge_d  = '0;
                    mosi_d  = cpha_i ? 1'b0 : first_bit;
                end
            end
            SETUP: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick) begin
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 7'd1;
                    // Odd (leading) edges sample when cpha=0, shift when cpha=1.
                    if (edge_q[0] == cpha_q) begin
                        rxsh_d = rxsh_q | (spi_miso_i ? (ONE << s_pos) : '0);
                    end else begin
                        mosi_d = d_bit;
                    end
                    if ((edge_q + 7'd1) == (nbits << 1)) state_d = HOLD;
                end
            end
            HOLD: begin
                sck_d = cpol_q;
                if (tick) begin
                    state_d = IDLE;
                    mosi_d  = 1'b0;
                    rxd_d   = rxsh_q;
                    rxv_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && !en_i) begin
            state_d = IDLE;
            sck_d   = cpol_i;
            mosi_d  = 1'b0;
            rxd_d   = rxd_q;
            rxv_d   = 1'b0;
            done_d  = 1'b0;
        end

        // Auto NSS is derived from the next state so it is registered in step
        // with the state itself.
        if (ass_i) begin
            nss_d = (state_d != IDLE) ? ~nssm_d : '1;
        end else begin
            nss_d = ~nss_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            dtb_q   <= '0;
            nssm_q  <= '0;
            tx_q    <= '0;
            rxsh_q  <= '0;
            edge_q  <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            nss_q   <= '1;
            rxd_q   <= '0;
            rxv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            dtb_q   <= dtb_d;
            nssm_q  <= nssm_d;
            tx_q    <= tx_d;
            rxsh_q  <= rxsh_d;
            edge_q  <= edge_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            nss_q   <= nss_d;
            rxd_q   <= rxd_d;
            rxv_q   <= rxv_d;
            done_q  <= done_d;
        end
    end

    // Gated by reset so the handshake stays closed while reset is held.
    assign tx_ready_o = (state_q == IDLE) & en_i & rst_n_i;
    assign busy_o     = (state_q != IDLE);
    assign rx_valid_o = rxv_q;
    assign rx_data_o  = rxd_q;
    assign done_o     = done_q;
    assign spi_sck_o  = sck_q;
    assign spi_nss_o  = nss_q;
    assign spi_mosi_o = mosi_q;

endmodule
